// File: rtl/llmgr_linksrv.sv
// Link-memory server: owns the page link memory and the free-page list threaded through it.
// Optional double-free detection is enabled by defining LLMGR_LINKSRV_DBLFREE_EN.
module llmgr_linksrv #(
  parameter int lpsz  = 8,
  parameter int lpdsz = lpsz + 1
) (
  input  logic             clk,
  input  logic             reset,
  output logic             par_srdy,
  input  logic             par_drdy,
  output logic [lpsz-1:0]  par_page,
  input  logic             lnp_srdy,
  output logic             lnp_drdy,
  input  logic [lpsz-1:0]  lnp_addr,
  input  logic [lpdsz-1:0] lnp_data,
  input  logic             rlp_srdy,
  output logic             rlp_drdy,
  input  logic [lpsz-1:0]  rlp_rd_page,
  output logic             rlpr_srdy,
  input  logic             rlpr_drdy,
  output logic [lpdsz-1:0] rlpr_data,
  input  logic             lprt_srdy,
  output logic             lprt_drdy,
  input  logic [lpsz-1:0]  lprt_page_list,
  output logic [lpsz:0]    free_cnt,
  output logic             err_dblfree
);

  localparam int               npages    = 1 << lpsz;
  localparam logic [lpsz-1:0]  last_page = '1;
  localparam logic [lpdsz-1:0] stop_page = {1'b1, {(lpdsz-1){1'b0}}};
  localparam logic [lpsz:0]    full_cnt  = {1'b1, {lpsz{1'b0}}};

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t           state_reg;
  logic [lpsz-1:0]  init_ptr_reg;
  logic [lpsz-1:0]  free_head_reg;
  logic [lpsz-1:0]  free_tail_reg;
  logic [lpsz:0]    free_cnt_reg;
  logic [lpsz:0]    free_cnt_next;
  logic             head_pend_reg;
  logic             rd_busy_reg;
  logic             rd_fresh_reg;
  logic [lpdsz-1:0] rlpr_hold_reg;

  logic [lpdsz-1:0] mem [npages];
  logic [lpdsz-1:0] mem_rd_reg;
  logic             mem_we;
  logic [lpsz-1:0]  mem_waddr;
  logic [lpdsz-1:0] mem_wdata;
  logic [lpsz-1:0]  mem_raddr;

  logic run, par_xfer, rlp_xfer, lprt_xfer, lnp_xfer, ret_valid, ret_link;

  assign run       = (state_reg == S_RUN);
  assign par_srdy  = run && (free_cnt_reg != '0) && !head_pend_reg;
  assign par_page  = free_head_reg;
  assign par_xfer  = par_srdy && par_drdy;
  assign rlp_drdy  = run && !rd_busy_reg && !par_xfer;
  assign rlp_xfer  = rlp_srdy && rlp_drdy;
  // A return racing an allocation would touch the list head while it is being replaced.
  assign lprt_drdy = run && !(par_xfer && ((free_cnt_reg <= (lpsz+1)'(1)) || head_pend_reg));
  assign lprt_xfer = lprt_srdy && lprt_drdy;
  assign lnp_drdy  = run && !lprt_xfer;
  assign lnp_xfer  = lnp_srdy && lnp_drdy;
  assign ret_link  = lprt_xfer && ret_valid && ((free_cnt_reg != full_cnt) || par_xfer);
  assign free_cnt_next = free_cnt_reg + (lpsz+1)'(ret_link) - (lpsz+1)'(par_xfer);

  assign free_cnt  = free_cnt_reg;
  assign rlpr_srdy = rd_busy_reg;
  // The first response cycle reads the RAM register directly; afterwards a held copy.
  assign rlpr_data = rd_fresh_reg ? mem_rd_reg : rlpr_hold_reg;
  assign mem_raddr = par_xfer ? free_head_reg : rlp_rd_page;

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = init_ptr_reg;
    mem_wdata = stop_page;
    if (state_reg == S_INIT) begin
      mem_we = 1'b1;
      if (init_ptr_reg != last_page)
        mem_wdata = lpdsz'(init_ptr_reg + lpsz'(1));
    end else if (ret_link && (free_cnt_reg != '0)) begin
      mem_we    = 1'b1;
      mem_waddr = free_tail_reg;
      mem_wdata = lpdsz'(lprt_page_list);
    end else if (lnp_xfer) begin
      mem_we    = 1'b1;
      mem_waddr = lnp_addr;
      mem_wdata = lnp_data;
    end
  end

  // Write-first single-port-read RAM.
  always_ff @(posedge clk) begin
    if (mem_we)
      mem[mem_waddr] <= mem_wdata;
    mem_rd_reg <= (mem_we && (mem_waddr == mem_raddr)) ? mem_wdata : mem[mem_raddr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= S_INIT;
      init_ptr_reg  <= '0;
      free_head_reg <= '0;
      free_tail_reg <= '0;
      free_cnt_reg  <= '0;
      head_pend_reg <= 1'b0;
      rd_busy_reg   <= 1'b0;
      rd_fresh_reg  <= 1'b0;
      rlpr_hold_reg <= '0;
    end else begin
      case (state_reg)
        S_INIT: begin
          init_ptr_reg <= init_ptr_reg + lpsz'(1);
          if (init_ptr_reg == last_page) begin
            state_reg     <= S_RUN;
            free_head_reg <= '0;
            free_tail_reg <= last_page;
            free_cnt_reg  <= full_cnt;
          end
        end
        default: begin
          free_cnt_reg  <= free_cnt_next;
          head_pend_reg <= par_xfer;
          if (head_pend_reg)
            free_head_reg <= mem_rd_reg[lpsz-1:0];
          // Refilling an empty list overrides the stale head fetched for the last page.
          if (ret_link) begin
            free_tail_reg <= lprt_page_list;
            if (free_cnt_reg == '0)
              free_head_reg <= lprt_page_list;
          end
          if (rlp_xfer)
            rd_busy_reg <= 1'b1;
          else if (rlpr_drdy)
            rd_busy_reg <= 1'b0;
          rd_fresh_reg <= rlp_xfer;
          if (rd_fresh_reg)
            rlpr_hold_reg <= mem_rd_reg;
        end
      endcase
    end
  end

`ifdef LLMGR_LINKSRV_DBLFREE_EN
  logic [npages-1:0] alloc_map_reg;
  logic [npages-1:0] alloc_map_next;
  logic              err_reg;

  assign ret_valid   = alloc_map_reg[lprt_page_list];
  assign err_dblfree = err_reg;

  genvar gi;
  generate
    for (gi = 0; gi < npages; gi++) begin : g_map
      assign alloc_map_next[gi] =
        (par_xfer && (free_head_reg == lpsz'(gi)))   ? 1'b1 :
        (lprt_xfer && (lprt_page_list == lpsz'(gi))) ? 1'b0 : alloc_map_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      alloc_map_reg <= '0;
      err_reg       <= 1'b0;
    end else begin
      alloc_map_reg <= alloc_map_next;
      if (lprt_xfer && !ret_valid)
        err_reg <= 1'b1;
    end
  end
`else
  assign ret_valid   = 1'b1;
  assign err_dblfree = 1'b0;
`endif

endmodule

// File: tb/tb_llmgr_linksrv.sv
// Bench for llmgr_linksrv: directed test-plan sequences plus random traffic
// checked every cycle against a queue-based free-list model.
module tb_llmgr_linksrv;

  localparam int NP = 16;
`ifdef LLMGR_LINKSRV_DBLFREE_EN
  localparam bit DBL = 1'b1;
`else
  localparam bit DBL = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       par_srdy, par_drdy;
  logic [3:0] par_page;
  logic       lnp_srdy, lnp_drdy;
  logic [3:0] lnp_addr;
  logic [4:0] lnp_data;
  logic       rlp_srdy, rlp_drdy;
  logic [3:0] rlp_rd_page;
  logic       rlpr_srdy, rlpr_drdy;
  logic [4:0] rlpr_data;
  logic       lprt_srdy, lprt_drdy;
  logic [3:0] lprt_page_list;
  logic [4:0] free_cnt;
  logic       err_dblfree;

  always #5 clk = ~clk;

  llmgr_linksrv #(.lpsz(4), .lpdsz(5)) dut (
    .clk(clk), .reset(reset),
    .par_srdy(par_srdy), .par_drdy(par_drdy), .par_page(par_page),
    .lnp_srdy(lnp_srdy), .lnp_drdy(lnp_drdy), .lnp_addr(lnp_addr), .lnp_data(lnp_data),
    .rlp_srdy(rlp_srdy), .rlp_drdy(rlp_drdy), .rlp_rd_page(rlp_rd_page),
    .rlpr_srdy(rlpr_srdy), .rlpr_drdy(rlpr_drdy), .rlpr_data(rlpr_data),
    .lprt_srdy(lprt_srdy), .lprt_drdy(lprt_drdy), .lprt_page_list(lprt_page_list),
    .free_cnt(free_cnt), .err_dblfree(err_dblfree)
  );

  int n_checks = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: free list as a queue, link values written by clients.
  int         fl[$];
  int         al_q[$];
  int         dut_alloc_q[$];
  bit         alloc_m[NP];
  bit         known[NP];
  logic [4:0] lnk[NP];
  bit         cool, rsp_busy, rsp_known, err_m, log_en;
  logic [4:0] rsp_val;
  int         init_left;

  task automatic idle();
    par_drdy = 0; lnp_srdy = 0; rlp_srdy = 0; rlpr_drdy = 0; lprt_srdy = 0;
    lnp_addr = 0; lnp_data = 0; rlp_rd_page = 0; lprt_page_list = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_par_srdy", par_srdy, 0);
    chk("rst_rlp_drdy", rlp_drdy, 0);
    chk("rst_rlpr_srdy", rlpr_srdy, 0);
    chk("rst_rlpr_data", rlpr_data, 0);
    chk("rst_free_cnt", free_cnt, 0);
    chk("rst_err", err_dblfree, 0);
    reset = 1'b0;
    fl.delete(); al_q.delete(); dut_alloc_q.delete();
    for (int i = 0; i < NP; i++) begin alloc_m[i] = 0; known[i] = 0; lnk[i] = 0; end
    cool = 0; rsp_busy = 0; rsp_known = 0; err_m = 0; init_left = NP;
  endtask

  // Check one cycle against the model, then advance the model and the clock.
  task automatic step();
    bit e_par_srdy, par_x, e_rlp_drdy, rlp_x, e_lprt_drdy, lprt_x, e_lnp_drdy, lnp_x, ok;
    int p, pg;
    #3;
    if (init_left > 0) begin
      chk("init_par_srdy", par_srdy, 0);
      chk("init_rlp_drdy", rlp_drdy, 0);
      chk("init_lprt_drdy", lprt_drdy, 0);
      chk("init_lnp_drdy", lnp_drdy, 0);
      chk("init_rlpr_srdy", rlpr_srdy, 0);
      chk("init_free_cnt", free_cnt, 0);
      init_left--;
      if (init_left == 0)
        for (int i = 0; i < NP; i++) fl.push_back(i);
    end else begin
      e_par_srdy  = (fl.size() != 0) && !cool;
      par_x       = e_par_srdy && par_drdy;
      e_rlp_drdy  = !rsp_busy && !par_x;
      rlp_x       = rlp_srdy && e_rlp_drdy;
      e_lprt_drdy = !(par_x && (fl.size() <= 1));
      lprt_x      = lprt_srdy && e_lprt_drdy;
      e_lnp_drdy  = !lprt_x;
      lnp_x       = lnp_srdy && e_lnp_drdy;
      chk("par_srdy", par_srdy, e_par_srdy);
      if (e_par_srdy) chk("par_page", par_page, fl[0]);
      chk("rlp_drdy", rlp_drdy, e_rlp_drdy);
      chk("lprt_drdy", lprt_drdy, e_lprt_drdy);
      chk("lnp_drdy", lnp_drdy, e_lnp_drdy);
      chk("rlpr_srdy", rlpr_srdy, rsp_busy);
      if (rsp_busy && rsp_known) chk("rlpr_data", rlpr_data, rsp_val);
      chk("free_cnt", free_cnt, fl.size());
      chk("err_dblfree", err_dblfree, err_m);

      pg = int'(lprt_page_list);
      ok = DBL ? alloc_m[pg] : 1'b1;
      if (rsp_busy && rlpr_drdy) begin
        rsp_busy = 0;
        if (log_en) $display("[%0t] read rsp data 0x%0h", $time, rlpr_data);
      end
      cool = par_x;
      if (par_x) begin
        p = fl.pop_front();
        known[p] = 0; alloc_m[p] = 1; al_q.push_back(p);
        dut_alloc_q.push_back(int'(par_page));
        if (log_en) $display("[%0t] alloc page %0d", $time, par_page);
      end
      if (lprt_x) begin
        if (!ok) err_m = 1;
        else begin
          if (fl.size() > 0) known[fl[$]] = 0;
          fl.push_back(pg);
          alloc_m[pg] = 0; known[pg] = 0;
          for (int i = 0; i < al_q.size(); i++)
            if (al_q[i] == pg) begin al_q.delete(i); break; end
        end
        if (log_en) $display("[%0t] return page %0d", $time, pg);
      end
      if (lnp_x) begin
        lnk[lnp_addr] = lnp_data; known[lnp_addr] = 1;
        if (log_en) $display("[%0t] link page %0d -> 0x%0h", $time, lnp_addr, lnp_data);
      end
      if (rlp_x) begin
        rsp_busy = 1; rsp_known = known[rlp_rd_page]; rsp_val = lnk[rlp_rd_page];
        if (log_en) $display("[%0t] read req page %0d", $time, rlp_rd_page);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic lnp_wr(input int a, input logic [4:0] d);
    lnp_srdy = 1; lnp_addr = 4'(a); lnp_data = d;
    step();
    lnp_srdy = 0;
  endtask

  task automatic lprt_ret(input int p);
    lprt_srdy = 1; lprt_page_list = 4'(p);
    step();
    lprt_srdy = 0;
  endtask

  task automatic rd(input int p, input logic [4:0] expv);
    rlp_srdy = 1; rlp_rd_page = 4'(p); rlpr_drdy = 0;
    step();
    rlp_srdy = 0;
    chk("rd_latency", rlpr_srdy, 1);
    chk("rd_data", rlpr_data, expv);
    rlpr_drdy = 1;
    step();
    rlpr_drdy = 0;
  endtask

  task automatic rand_inputs();
    par_drdy  = ($urandom_range(0, 2) != 0);
    rlpr_drdy = ($urandom_range(0, 3) != 0);
    rlp_srdy  = ($urandom_range(0, 2) == 0);
    if (al_q.size() > 0 && $urandom_range(0, 3) != 0)
      rlp_rd_page = 4'(al_q[$urandom_range(0, al_q.size() - 1)]);
    else
      rlp_rd_page = 4'($urandom);
    lnp_srdy = (al_q.size() > 0) && ($urandom_range(0, 2) == 0);
    if (lnp_srdy) begin
      lnp_addr = 4'(al_q[$urandom_range(0, al_q.size() - 1)]);
      lnp_data = 5'($urandom);
    end
    lprt_srdy = (al_q.size() > 0) && ($urandom_range(0, 2) == 0);
    if (lprt_srdy) lprt_page_list = 4'(al_q[$urandom_range(0, al_q.size() - 1)]);
    if (DBL && $urandom_range(0, 19) == 0) begin
      lprt_srdy = 1; lprt_page_list = 4'($urandom);
    end
  endtask

  initial begin
    log_en = 1;
    do_reset();

    // Initialisation, then 16 in-order allocations until empty.
    repeat (NP) step();
    chk("init_cnt", free_cnt, 16);
    par_drdy = 1;
    repeat (2 * NP + 2) step();
    par_drdy = 0;
    chk("alloc_count", dut_alloc_q.size(), 16);
    for (int k = 0; k < NP; k++) chk("alloc_order", dut_alloc_q[k], k);
    chk("empty_srdy", par_srdy, 0);

    // Link writes and read-backs.
    do_reset();
    repeat (NP) step();
    par_drdy = 1;
    repeat (6) step();
    par_drdy = 0;
    lnp_wr(0, 5'h01); lnp_wr(1, 5'h02); lnp_wr(2, 5'h10);
    rd(0, 5'h01); rd(1, 5'h02); rd(2, 5'h10);

    // Response stall: held data, no new request accepted until consumed.
    rlp_srdy = 1; rlp_rd_page = 4'd0; rlpr_drdy = 0;
    step();
    rlp_rd_page = 4'd1;
    repeat (5) step();
    chk("stall_data", rlpr_data, 5'h01);
    rlpr_drdy = 1;
    step();
    rlpr_drdy = 0;
    step();
    rlp_srdy = 0;
    chk("stall_next_data", rlpr_data, 5'h02);
    rlpr_drdy = 1;
    step();
    idle();

    // Drain, return 5 and 9, reallocate in return order.
    do_reset();
    repeat (NP) step();
    par_drdy = 1;
    repeat (2 * NP) step();
    par_drdy = 0;
    lprt_ret(5); lprt_ret(9);
    chk("ret_cnt", free_cnt, 2);
    par_drdy = 1;
    repeat (4) step();
    par_drdy = 0;
    chk("realloc_a", dut_alloc_q[16], 5);
    chk("realloc_b", dut_alloc_q[17], 9);
    chk("realloc_cnt", free_cnt, 0);

    // One free page: allocation wins over a simultaneous return.
    lprt_ret(7);
    par_drdy = 1; lprt_srdy = 1; lprt_page_list = 4'd5;
    step();
    par_drdy = 0;
    step();
    lprt_srdy = 0;
    chk("race_alloc", dut_alloc_q[18], 7);
    chk("race_cnt", free_cnt, 1);

    // Double free of page 3.
    do_reset();
    repeat (NP) step();
    par_drdy = 1;
    repeat (8) step();
    par_drdy = 0;
    lprt_ret(3);
    if (DBL) begin
      lprt_ret(3);
      chk("dbl_err", err_dblfree, 1);
    end else begin
      step();
      chk("nodbl_err", err_dblfree, 0);
    end
    chk("dbl_cnt", free_cnt, 13);

    // Random traffic with a mid-run reset.
    log_en = 0;
    do_reset();
    for (int c = 0; c < 1600; c++) begin
      if (c == 800) do_reset();
      rand_inputs();
      step();
    end
    idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
